// File: rtl/output_collector.sv
// output_collector: requantises captured MAC results into a small FIFO drained over valid/ready,
// with stall back-pressure, sticky overflow and a layer_done pulse once a layer has fully drained.
module output_collector #(
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int COORD_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        running,
  input  logic                        output_valid,
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  input  logic [COORD_WIDTH-1:0]      output_x,
  input  logic [COORD_WIDTH-1:0]      output_y,
  input  logic [COORD_WIDTH-1:0]      output_ch,
  input  logic [4:0]                  shift,
  output logic                        stall,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [COORD_WIDTH-1:0]      out_x,
  output logic [COORD_WIDTH-1:0]      out_y,
  output logic [COORD_WIDTH-1:0]      out_ch,
  output logic                        overflow,
  output logic                        layer_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic signed [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            wr_q, rd_q;
  logic [CW-1:0]            count_q, count_d;
  logic                     overflow_q;
  logic [OUT_WIDTH-1:0]     data_mem [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0]   x_mem    [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0]   y_mem    [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0]   ch_mem   [FIFO_DEPTH];
  logic signed [ACC_WIDTH-1:0] sh;
  logic [OUT_WIDTH-1:0]     q;
  logic                     push, pop;

  assign sh = acc_in >>> shift;
  assign q  = sh > QMAX ? QMAX[OUT_WIDTH-1:0] : sh < QMIN ? QMIN[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];

  assign stall     = count_q == CW'(FIFO_DEPTH);
  assign out_valid = count_q != '0;
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push      = output_valid && (!stall || pop);
  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign overflow  = overflow_q;

  // Head is gated by out_valid so outputs read zero whenever the FIFO is empty or in reset.
  assign out_data = out_valid ? data_mem[rd_q] : '0;
  assign out_x    = out_valid ? x_mem[rd_q]    : '0;
  assign out_y    = out_valid ? y_mem[rd_q]    : '0;
  assign out_ch   = out_valid ? ch_mem[rd_q]   : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_q] <= q;
      x_mem[wr_q]    <= output_x;
      y_mem[wr_q]    <= output_y;
      ch_mem[wr_q]   <= output_ch;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_q + AW'(push);
      rd_q       <= rd_q + AW'(pop);
      count_q    <= count_d;
      overflow_q <= overflow_q || (output_valid && !push);
    end
  end

  always_comb begin
    state_d    = IDLE;
    layer_done = 1'b0;
    case (state_q)
      IDLE:    state_d = running ? ACTIVE : IDLE;
      ACTIVE:  state_d = running ? ACTIVE : DRAIN;
      DRAIN: begin
        state_d    = running ? ACTIVE : (count_q == '0 ? IDLE : DRAIN);
        layer_done = !running && count_q == '0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_output_collector.sv
// tb_output_collector: random and directed pushes scored against a queue-based reference model.
module tb_output_collector;
  logic               clk = 1'b0;
  logic               arst_n_in, running, output_valid, out_ready;
  logic signed [31:0] acc_in;
  logic [31:0]        output_x, output_y, output_ch;
  logic [4:0]         shift;
  logic               stall, out_valid, overflow, layer_done;
  logic [15:0]        out_data;
  logic [31:0]        out_x, out_y, out_ch;

  output_collector dut (
    .clk(clk), .arst_n_in(arst_n_in), .running(running), .output_valid(output_valid),
    .acc_in(acc_in), .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .shift(shift), .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .overflow(overflow), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [31:0] x, y, ch;
  } ent_t;

  ent_t exp_q[$];
  int   vecs = 0, errs = 0, done_cnt = 0;
  bit   chk_en = 0, popped = 0, ovf_exp = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // Floor division by 2^s then clamp to the signed 16-bit range.
  function automatic logic [15:0] requant(input logic [31:0] a, input int s);
    longint v, d, r;
    v = longint'($signed(a));
    d = longint'(1) << s;
    r = v / d;
    if (v % d != 0 && v < 0) r = r - 1;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // Model consumes the inputs the DUT samples on this edge, then drives the next cycle's inputs.
  task automatic step(input bit ov, input bit rdy, input bit run, input logic [31:0] acc,
                      input logic [4:0] sh, input logic [31:0] x);
    bit full_b;
    @(posedge clk);
    if (output_valid) begin
      full_b = (exp_q.size() + int'(popped)) == 4;
      if (!full_b || popped) exp_q.push_back({requant(acc_in, int'(shift)), output_x, output_y, output_ch});
      else ovf_exp = 1;
    end
    popped = 0;
    #1;
    output_valid = ov; out_ready = rdy; running = run;
    acc_in = acc; shift = sh;
    output_x = x; output_y = x ^ 32'h00AA_0000; output_ch = ~x;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
      chk("stall", {31'd0, stall}, {31'd0, exp_q.size() == 4});
      chk("overflow", {31'd0, overflow}, {31'd0, ovf_exp});
      if (layer_done) begin
        done_cnt++;
        chk("done_when_empty", exp_q.size(), 0);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("out_data", {16'd0, out_data}, {16'd0, e.d});
        chk("out_x", out_x, e.x);
        chk("out_y", out_y, e.y);
        chk("out_ch", out_ch, e.ch);
        popped = 1;
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {16'd0, out_data}, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_layer_done", {31'd0, layer_done}, 0);
  endtask

  logic [31:0] acc_r;
  int          n;

  initial begin
    arst_n_in = 0; running = 0; output_valid = 0; out_ready = 0;
    acc_in = 0; shift = 0; output_x = 0; output_y = 0; output_ch = 0;
    #3 chk_reset_vals();
    @(negedge clk); arst_n_in = 1;
    @(negedge clk); chk_en = 1;
    // directed: basic push and saturation corners
    step(1, 1, 1, 32'h0000_0300, 4, 32'd10);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h7FFF_FFFF, 0, 32'd11);
    step(1, 1, 1, 32'h8000_0000, 0, 32'd12);
    step(1, 1, 1, 32'hFFFF_FFFB, 1, 32'd13);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("sat_pos", {16'd0, requant(32'h7FFF_FFFF, 0)}, 32'h7FFF);
    chk("sat_neg", {16'd0, requant(32'h8000_0000, 0)}, 32'h8000);
    // random traffic, biased to fill so full-with-pop and overflow occur
    for (int i = 0; i < 400; i++) begin
      case ($urandom % 4)
        0: acc_r = 32'h7FFF_FFFF;
        1: acc_r = 32'h8000_0000;
        default: acc_r = $urandom;
      endcase
      step(($urandom % 100) < 55, ($urandom % 100) < 40, 1, acc_r, 5'($urandom % 32), $urandom);
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin step(0, 1, 1, 0, 0, 0); n++; end
    step(0, 1, 1, 0, 0, 0);
    chk("drain_random", exp_q.size(), 0);
    chk("no_done_while_running", done_cnt, 0);
    // fill to full with x=0..4 so the fifth is dropped, then drain in order
    for (int i = 0; i < 5; i++) step(1, 0, 1, $urandom, 3, 32'(i));
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0);
    // layer end with two entries queued
    step(1, 0, 1, 32'h1234, 2, 32'd100);
    step(1, 0, 1, 32'h5678, 2, 32'd101);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
    chk("layer_done_once", done_cnt, 1);
    // async reset with three entries queued and overflow set
    for (int i = 0; i < 5; i++) step(1, 0, 1, $urandom, 0, 32'(200 + i));
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("pre_reset_depth", exp_q.size(), 3);
    chk("pre_reset_overflow", {31'd0, overflow}, 1);
    @(posedge clk); #3;
    chk_en = 0; arst_n_in = 0; running = 0;
    #1 chk_reset_vals();
    exp_q.delete(); ovf_exp = 0; popped = 0;
    done_cnt = 0;
    @(negedge clk); arst_n_in = 1;
    @(negedge clk); chk_en = 1;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    chk("no_done_after_reset", done_cnt, 0);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
